// File: rtl/rvfi_trace_pkg.sv
// rtl/rvfi_trace_pkg.sv - entry/packet types for rvfi_trace_gen; RVFI_TRACE_MEM_EN adds memory fields to entries
package rvfi_trace_pkg;

    localparam int RVFI_XLEN  = 32;
    localparam int RVFI_ILEN  = 32;
    localparam int RVFI_MASKW = RVFI_XLEN / 8;

    typedef struct packed {
        logic [RVFI_ILEN-1:0] insn;
        logic [RVFI_XLEN-1:0] pc;
        logic                 intr;
        logic                 halt;
        logic [4:0]           rs1_addr;
        logic [4:0]           rs2_addr;
        logic [RVFI_XLEN-1:0] rs1_rdata;
        logic [RVFI_XLEN-1:0] rs2_rdata;
    } issue_half_t;

    typedef struct packed {
        logic                  trap;
        logic [4:0]            rd_addr;
        logic [RVFI_XLEN-1:0]  rd_wdata;
        logic [RVFI_XLEN-1:0]  pc_wdata;
`ifdef RVFI_TRACE_MEM_EN
        logic [RVFI_XLEN-1:0]  mem_addr;
        logic [RVFI_MASKW-1:0] mem_rmask;
        logic [RVFI_MASKW-1:0] mem_wmask;
        logic [RVFI_XLEN-1:0]  mem_rdata;
        logic [RVFI_XLEN-1:0]  mem_wdata;
`endif
    } cmpl_half_t;

    typedef struct packed {
        logic        busy;
        logic        done;
        issue_half_t iss;
        cmpl_half_t  cmp;
    } entry_t;

    typedef struct packed {
        logic                  valid;
        logic [63:0]           order;
        logic [RVFI_ILEN-1:0]  insn;
        logic                  trap;
        logic                  halt;
        logic                  intr;
        logic [4:0]            rs1_addr;
        logic [4:0]            rs2_addr;
        logic [4:0]            rd_addr;
        logic [RVFI_XLEN-1:0]  rs1_rdata;
        logic [RVFI_XLEN-1:0]  rs2_rdata;
        logic [RVFI_XLEN-1:0]  rd_wdata;
        logic [RVFI_XLEN-1:0]  pc_rdata;
        logic [RVFI_XLEN-1:0]  pc_wdata;
        logic [RVFI_XLEN-1:0]  mem_addr;
        logic [RVFI_MASKW-1:0] mem_rmask;
        logic [RVFI_MASKW-1:0] mem_wmask;
        logic [RVFI_XLEN-1:0]  mem_rdata;
        logic [RVFI_XLEN-1:0]  mem_wdata;
    } rvfi_pkt_t;

    localparam rvfi_pkt_t RVFI_PKT_ZERO = '0;

endpackage

// File: rtl/rvfi_trace_pkt_reg.sv
// rtl/rvfi_trace_pkt_reg.sv - RVFI output packet register; valid is a one-cycle pulse, other fields hold
module rvfi_trace_pkt_reg
    import rvfi_trace_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      load,
    input  rvfi_pkt_t pkt_d,
    output rvfi_pkt_t pkt_q
);

    always_ff @(posedge clock) begin
        if (!reset) begin
            pkt_q <= RVFI_PKT_ZERO;
        end else if (load) begin
            pkt_q <= pkt_d;
        end else begin
            pkt_q.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rvfi_trace_gen.sv
// rtl/rvfi_trace_gen.sv - in-order RVFI packet producer with out-of-order completion by tag
// RVFI_TRACE_MEM_EN: store cmpl_mem_* per entry and drive rvfi_mem_*; otherwise rvfi_mem_* are 0
module rvfi_trace_gen
    import rvfi_trace_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int ILEN  = 32,
    parameter  int DEPTH = 4,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [ILEN-1:0]   issue_insn,
    input  logic [XLEN-1:0]   issue_pc,
    input  logic              issue_intr,
    input  logic [4:0]        issue_rs1_addr,
    input  logic [4:0]        issue_rs2_addr,
    input  logic [XLEN-1:0]   issue_rs1_rdata,
    input  logic [XLEN-1:0]   issue_rs2_rdata,
    output logic [TW-1:0]     issue_tag,
    input  logic              cmpl_valid,
    input  logic [TW-1:0]     cmpl_tag,
    input  logic              cmpl_trap,
    input  logic [4:0]        cmpl_rd_addr,
    input  logic [XLEN-1:0]   cmpl_rd_wdata,
    input  logic [XLEN-1:0]   cmpl_pc_wdata,
    input  logic [XLEN-1:0]   cmpl_mem_addr,
    input  logic [XLEN/8-1:0] cmpl_mem_rmask,
    input  logic [XLEN/8-1:0] cmpl_mem_wmask,
    input  logic [XLEN-1:0]   cmpl_mem_rdata,
    input  logic [XLEN-1:0]   cmpl_mem_wdata,
    input  logic              halt_req,
    output logic              err,
    output logic              rvfi_valid,
    output logic              rvfi_trap,
    output logic              rvfi_halt,
    output logic              rvfi_intr,
    output logic [63:0]       rvfi_order,
    output logic [ILEN-1:0]   rvfi_insn,
    output logic [4:0]        rvfi_rs1_addr,
    output logic [4:0]        rvfi_rs2_addr,
    output logic [4:0]        rvfi_rd_addr,
    output logic [XLEN-1:0]   rvfi_rs1_rdata,
    output logic [XLEN-1:0]   rvfi_rs2_rdata,
    output logic [XLEN-1:0]   rvfi_rd_wdata,
    output logic [XLEN-1:0]   rvfi_pc_rdata,
    output logic [XLEN-1:0]   rvfi_pc_wdata,
    output logic [XLEN-1:0]   rvfi_mem_addr,
    output logic [XLEN/8-1:0] rvfi_mem_rmask,
    output logic [XLEN/8-1:0] rvfi_mem_wmask,
    output logic [XLEN-1:0]   rvfi_mem_rdata,
    output logic [XLEN-1:0]   rvfi_mem_wdata
);

    entry_t        ent [DEPTH];
    logic [TW-1:0] head;
    logic [TW-1:0] tail;
    logic [TW:0]   count;
    logic [63:0]   order;
    logic          halted;
    logic          issue_fire;
    logic          cmpl_ok;
    logic          retire;
    issue_half_t   iss_d;
    cmpl_half_t    cmp_d;
    rvfi_pkt_t     pkt_d;
    rvfi_pkt_t     pkt_q;

    // A full buffer stalls issue even if the head retires this cycle.
    assign issue_ready = (count < (TW+1)'(DEPTH)) && !halted;
    assign issue_fire  = issue_valid && issue_ready;
    assign issue_tag   = tail;
    assign cmpl_ok     = ent[cmpl_tag].busy && !ent[cmpl_tag].done;
    assign retire      = ent[head].done;

    always_comb begin
        iss_d           = '0;
        iss_d.insn      = issue_insn;
        iss_d.pc        = issue_pc;
        iss_d.intr      = issue_intr;
        iss_d.halt      = halt_req;
        iss_d.rs1_addr  = issue_rs1_addr;
        iss_d.rs2_addr  = issue_rs2_addr;
        iss_d.rs1_rdata = issue_rs1_rdata;
        iss_d.rs2_rdata = issue_rs2_rdata;
    end

    always_comb begin
        cmp_d          = '0;
        cmp_d.trap     = cmpl_trap;
        cmp_d.rd_addr  = cmpl_rd_addr;
        cmp_d.rd_wdata = (cmpl_rd_addr == 5'd0) ? '0 : cmpl_rd_wdata;
        cmp_d.pc_wdata = cmpl_pc_wdata;
`ifdef RVFI_TRACE_MEM_EN
        cmp_d.mem_addr  = cmpl_mem_addr;
        cmp_d.mem_rmask = cmpl_mem_rmask;
        cmp_d.mem_wmask = cmpl_mem_wmask;
        cmp_d.mem_rdata = cmpl_mem_rdata;
        cmp_d.mem_wdata = cmpl_mem_wdata;
`endif
    end

`ifndef RVFI_TRACE_MEM_EN
    logic unused_mem;
    assign unused_mem = ^{cmpl_mem_addr, cmpl_mem_rmask, cmpl_mem_wmask,
                          cmpl_mem_rdata, cmpl_mem_wdata};
`endif

    always_comb begin
        pkt_d           = RVFI_PKT_ZERO;
        pkt_d.valid     = 1'b1;
        pkt_d.order     = order;
        pkt_d.insn      = ent[head].iss.insn;
        pkt_d.trap      = ent[head].cmp.trap;
        pkt_d.halt      = ent[head].iss.halt;
        pkt_d.intr      = ent[head].iss.intr;
        pkt_d.rs1_addr  = ent[head].iss.rs1_addr;
        pkt_d.rs2_addr  = ent[head].iss.rs2_addr;
        pkt_d.rd_addr   = ent[head].cmp.rd_addr;
        pkt_d.rs1_rdata = ent[head].iss.rs1_rdata;
        pkt_d.rs2_rdata = ent[head].iss.rs2_rdata;
        pkt_d.rd_wdata  = ent[head].cmp.rd_wdata;
        pkt_d.pc_rdata  = ent[head].iss.pc;
        pkt_d.pc_wdata  = ent[head].cmp.pc_wdata;
`ifdef RVFI_TRACE_MEM_EN
        pkt_d.mem_addr  = ent[head].cmp.mem_addr;
        pkt_d.mem_rdata = ent[head].cmp.mem_rdata;
        pkt_d.mem_wdata = ent[head].cmp.mem_wdata;
        // A trapped access performed no memory transfer.
        if (!ent[head].cmp.trap) begin
            pkt_d.mem_rmask = ent[head].cmp.mem_rmask;
            pkt_d.mem_wmask = ent[head].cmp.mem_wmask;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            order  <= '0;
            halted <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (issue_fire) begin
                ent[tail].busy <= 1'b1;
                ent[tail].done <= 1'b0;
                ent[tail].iss  <= iss_d;
                tail           <= tail + TW'(1);
                if (halt_req) begin
                    halted <= 1'b1;
                end
            end
            if (cmpl_valid) begin
                if (cmpl_ok) begin
                    ent[cmpl_tag].done <= 1'b1;
                    ent[cmpl_tag].cmp  <= cmp_d;
                end else begin
                    err <= 1'b1;
                end
            end
            if (retire) begin
                ent[head].busy <= 1'b0;
                ent[head].done <= 1'b0;
                head           <= head + TW'(1);
                order          <= order + 64'd1;
            end
            count <= count + (TW+1)'(issue_fire) - (TW+1)'(retire);
        end
    end

    rvfi_trace_pkt_reg u_pkt_reg (
        .clock (clock),
        .reset (reset),
        .load  (retire),
        .pkt_d (pkt_d),
        .pkt_q (pkt_q)
    );

    assign rvfi_valid     = pkt_q.valid;
    assign rvfi_order     = pkt_q.order;
    assign rvfi_insn      = pkt_q.insn;
    assign rvfi_trap      = pkt_q.trap;
    assign rvfi_halt      = pkt_q.halt;
    assign rvfi_intr      = pkt_q.intr;
    assign rvfi_rs1_addr  = pkt_q.rs1_addr;
    assign rvfi_rs2_addr  = pkt_q.rs2_addr;
    assign rvfi_rd_addr   = pkt_q.rd_addr;
    assign rvfi_rs1_rdata = pkt_q.rs1_rdata;
    assign rvfi_rs2_rdata = pkt_q.rs2_rdata;
    assign rvfi_rd_wdata  = pkt_q.rd_wdata;
    assign rvfi_pc_rdata  = pkt_q.pc_rdata;
    assign rvfi_pc_wdata  = pkt_q.pc_wdata;
    assign rvfi_mem_addr  = pkt_q.mem_addr;
    assign rvfi_mem_rmask = pkt_q.mem_rmask;
    assign rvfi_mem_wmask = pkt_q.mem_wmask;
    assign rvfi_mem_rdata = pkt_q.mem_rdata;
    assign rvfi_mem_wdata = pkt_q.mem_wdata;

endmodule

// File: doc/rvfi_trace_gen.md
# rvfi_trace_gen

In-order RVFI packet producer sitting between a core's issue/writeback stages and any RVFI consumer (instruction checkers, monitors). Instructions are registered at issue, completed out of order by tag, and retired strictly in program order as single-channel RVFI packets with a monotonically increasing order number. It drives exactly the `rvfi_*` fields the instruction checkers sample.

## Interface
- `XLEN`, 32, register/PC width
- `ILEN`, 32, instruction width
- `DEPTH`, 4, in-flight entries; power of two, ≥2; `TW = $clog2(DEPTH)`
- `clock`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-low
- `issue_valid` / `issue_ready`  in / out  1  issue handshake
- `issue_insn`  in  ILEN  instruction word
- `issue_pc`  in  XLEN  PC of instruction
- `issue_intr`  in  1  first instruction of a trap handler
- `issue_rs1_addr`, `issue_rs2_addr`  in  5  source register indices
- `issue_rs1_rdata`, `issue_rs2_rdata`  in  XLEN  source operand values
- `issue_tag`  out  TW  tag allocated to the current issue (valid when `issue_valid && issue_ready`)
- `cmpl_valid`  in  1  completion strobe (no backpressure)
- `cmpl_tag`  in  TW  entry being completed
- `cmpl_trap`  in  1  instruction trapped
- `cmpl_rd_addr`  in  5, `cmpl_rd_wdata`  in  XLEN, `cmpl_pc_wdata`  in  XLEN
- `cmpl_mem_addr`  in  XLEN, `cmpl_mem_rmask` / `cmpl_mem_wmask`  in  XLEN/8, `cmpl_mem_rdata` / `cmpl_mem_wdata`  in  XLEN
- `halt_req`  in  1  mark the next issued instruction as the final one
- `err`  out  1  sticky protocol error
- `rvfi_valid`, `rvfi_trap`, `rvfi_halt`, `rvfi_intr`  out  1
- `rvfi_order`  out  64
- `rvfi_insn`  out  ILEN
- `rvfi_rs1_addr`, `rvfi_rs2_addr`, `rvfi_rd_addr`  out  5
- `rvfi_rs1_rdata`, `rvfi_rs2_rdata`, `rvfi_rd_wdata`, `rvfi_pc_rdata`, `rvfi_pc_wdata`, `rvfi_mem_addr`, `rvfi_mem_rdata`, `rvfi_mem_wdata`  out  XLEN
- `rvfi_mem_rmask`, `rvfi_mem_wmask`  out  XLEN/8

## Operation
- **Storage:** circular buffer of DEPTH entries. Head and tail pointers are TW bits and wrap modulo DEPTH. Count is TW+1 bits. Each entry has `busy` and `done` flags.
- **Issue:**
  - `issue_ready = (count < DEPTH) && !halted`.
  - On handshake, the entry at tail captures the issue fields; `busy=1`, `done=0`; tail advances.
  - `issue_tag` equals tail.
- **Completion:**
  - When `cmpl_valid` targets an entry with `busy && !done`, the entry captures the completion fields and sets `done=1`.
  - A completion to a non-busy or already-done entry is dropped and sets `err`.
  - If `cmpl_rd_addr==0`, the stored `rd_wdata` is forced to 0.
- **Retire:**
  - Each cycle, if the head entry is `done`, the output register loads its packet with `rvfi_valid=1` and the current `rvfi_order`.
  - The head entry is then freed (`busy=0`), head advances, and the order counter increments.
  - At most one retire per cycle. `rvfi_valid` is a 1-cycle pulse.
  - When no retire occurs, `rvfi_valid=0` and the other `rvfi_*` outputs hold their previous values.
- **Halt:**
  - `halt_req` is sampled on an issue handshake. The issued entry gets `halt=1` and the `halted` flag sets.
  - The halt entry retires with `rvfi_halt=1`. No further issue is accepted until reset.
- **Simultaneous events:**
  - Issue, completion and retire may all occur in the same cycle.
  - `count` updates by +issue −retire.
  - Retire uses only entry state registered before the edge; there is no completion bypass.
  - `issue_ready` ignores a same-cycle retire, so a full buffer stalls issue for one cycle.
- **Reset** (also mid-operation): all entries cleared, head=tail=count=0, order=0, `halted=0`, `err=0`, every `rvfi_*` output = 0. In-flight instructions are discarded without a packet.

## Timing
- Issue is accepted at edge E0. The earliest completion is in the cycle after E0.
- Completion is captured at edge E1. `done` is visible in the next cycle; `rvfi_valid` is asserted after the following edge, i.e. the second cycle after E1.
- Completion-to-packet latency is 2 cycles when the entry is at head.
- Steady-state throughput is 1 packet/cycle.
- `rvfi_order` is 0 for the first packet after reset and increments by exactly 1 per packet; it wraps at 2^64.

## Configuration
- `RVFI_TRACE_MEM_EN` defined:
  - Entries store the `cmpl_mem_*` fields, and the `rvfi_mem_*` outputs carry them.
  - A trapped instruction retires with both masks forced to 0.
- `RVFI_TRACE_MEM_EN` not defined:
  - No memory storage.
  - All `rvfi_mem_*` outputs are constant 0.
  - The `cmpl_mem_*` inputs are ignored.

## Structure
- Package `rvfi_trace_pkg`:
  - Entry struct with separate issue and completion halves.
  - Packet struct mirroring the `rvfi_*` outputs.
  - The zero packet constant used at reset.
- Sub-module `rvfi_trace_pkt_reg`:
  - Output packet register with a load-enable.
  - Clears `rvfi_valid` when not loading.
  - Handles the reset clear.

## Test plan
- **In-order basic:** issue 3 instructions with PCs 0x0, 0x4, 0x8; complete tags 0, 1, 2 in consecutive cycles → 3 packets in consecutive cycles with `rvfi_order` 0, 1, 2 and `pc_rdata` 0x0, 0x4, 0x8.
- **Out-of-order completion:** issue tags 0–3; complete in order 3, 1, 2, 0 → no packet until 2 cycles after tag 0 completes, then 4 back-to-back packets in order 0–3.
- **Full:** 4 instructions outstanding → `issue_ready=0`; complete tag 0 → `issue_ready=1` one cycle after the retire; `issue_tag` wraps to 0.
- **rd zero and errors:** completion with `rd_addr=0`, `rd_wdata=0xDEADBEEF` → packet has `rd_wdata=0`; a second completion to the same tag → `err=1`, and no change to the stored data.
- **Halt:** issue with `halt_req=1` → that packet has `rvfi_halt=1`; `issue_ready` stays 0 thereafter.
- **Reset mid-flight:** 2 instructions outstanding, `reset=0` for one cycle → all outputs 0, no packets emitted; the next packet carries `rvfi_order=0`.
